cnt163_seq_ctrl: RTL and testbench
==================================

Name: cnt163_seq_ctrl

Overview:
- Sequencing controller for one 4-bit 74x163-style synchronous counter (sync clear, sync load, ENP/ENT count enables, all on CLK rising edge).
- Turns the free-running counter into a programmable-range modulo counter. It counts CFG_LO..CFG_HI for a programmed number of passes, with pause, abort and completion status.
- Sits beside the counter on the same CLK. It drives the counter's CLR_L/LD_L/ENP/ENT/D and observes its Q.

Parameters:
- W, 4, counter width (CNT_D, CNT_Q, CFG_LO, CFG_HI). Only 4 is required to be verified.
- PW, 4, width of the pass-count configuration and status.

Ports:
- CLK  input  1  system clock, rising edge; shared with the counter.
- RST_L  input  1  asynchronous active-low reset.
- START  input  1  level sampled in IDLE; starts a run.
- STOP  input  1  abort request; honoured in LOAD and RUN.
- HOLD  input  1  pause; honoured in RUN.
- CFG_LO  input  W  low bound of the range; latched on an accepted START.
- CFG_HI  input  W  high bound of the range; latched on an accepted START.
- CYCLES  input  PW  number of passes; 0 = continuous. Latched on an accepted START.
- CNT_Q  input  W  counter present state.
- CNT_CLR_L  output  1  counter sync clear, active low.
- CNT_LD_L  output  1  counter sync load, active low.
- CNT_ENP  output  1  counter ENP.
- CNT_ENT  output  1  counter ENT.
- CNT_D  output  W  counter load data.
- BUSY  output  1  high in LOAD, RUN and ABORT.
- DONE  output  1  one-cycle pulse on normal completion.
- WRAP_P  output  1  high during each RUN cycle in which a pass ends.
- ERR  output  1  sticky flag: START was rejected because CFG_LO > CFG_HI. Cleared by the next accepted START.
- PASS_CNT  output  PW  passes completed in the current run.

Behaviour:
- Registered state: IDLE, LOAD, RUN, DONE_S, ABORT. Also registered: lo_r, hi_r, cyc_r, PASS_CNT, ERR.
- Counter-control outputs are combinational from state, CNT_Q and the registers. The counter therefore acts on the same edge that the controller's state transition occurs.
- Reset (RST_L=0, asynchronous):
  - state=IDLE; lo_r=hi_r=cyc_r=0; PASS_CNT=0; ERR=0; BUSY=DONE=WRAP_P=0.
  - CNT_CLR_L forced 0 while RST_L=0. The counter is cleared on every edge during reset.
  - CNT_LD_L=1; ENP=ENT=0; CNT_D=0.
- IDLE:
  - CNT_CLR_L=1, LD_L=1, ENP=ENT=0. The counter holds its value.
  - START=1 with CFG_LO<=CFG_HI: latch the config, PASS_CNT<=0, ERR<=0, go to LOAD.
  - START=1 with CFG_LO>CFG_HI: ERR<=1, stay IDLE.
- LOAD (exactly 1 cycle):
  - LD_L=0, CNT_D=lo_r, ENP=ENT=0.
  - Next state RUN; Q=lo_r after the edge.
  - If STOP=1, go to ABORT instead; the load still occurs on that edge.
- RUN, evaluated in priority order:
  1. STOP=1: go to ABORT. Outputs this cycle are inactive (LD_L=1, ENP=ENT=0), so Q holds.
  2. HOLD=1: ENT=1, ENP=0, LD_L=1. Q frozen, no wrap evaluated, WRAP_P=0.
  3. CNT_Q!=hi_r: ENP=ENT=1. Q increments by 1.
  4. CNT_Q==hi_r (end of pass): WRAP_P=1 and PASS_CNT<=PASS_CNT+1, wrapping mod 2^PW. Then:
     - cyc_r!=0 and PASS_CNT+1==cyc_r: ENP=ENT=0, LD_L=1, go to DONE_S. Q remains hi_r.
     - otherwise: LD_L=0, CNT_D=lo_r, ENP=ENT=0. Q=lo_r next edge; stay RUN.
- CFG_LO==CFG_HI: every RUN cycle ends a pass; Q is reloaded each cycle.
- DONE_S: DONE=1 for exactly one cycle, counter held, then IDLE. START is ignored in DONE_S.
- ABORT: CNT_CLR_L=0 for exactly one cycle (Q=0 after the edge), then IDLE. PASS_CNT keeps its value.
- BUSY=1 in LOAD, RUN and ABORT; 0 in IDLE and DONE_S.
- HOLD outside RUN, and STOP in IDLE or DONE_S, have no effect.
- Config inputs may change freely during a run; only the latched copies are used.
- Async reset mid-run returns to IDLE immediately; no DONE is issued.

Test Plan:
- Reset: RST_L=0 for 3 edges with the counter at 9 -> Q=0, CNT_CLR_L=0 during reset; after release state=IDLE, all status 0.
- LO=3, HI=6, CYCLES=2, START pulse at edge e0:
  - Q=3 at e1; then 4, 5, 6, 3, 4, 5, 6.
  - WRAP_P high in the two cycles where Q=6.
  - DONE high in the cycle after e9; Q holds 6; PASS_CNT=2; BUSY low from DONE.
- LO=2, HI=2, CYCLES=0: Q stays 2; WRAP_P high every cycle; PASS_CNT counts 1..15, 0, 1...; never DONE. Then STOP -> one cycle CNT_CLR_L=0, Q=0, IDLE.
- HOLD asserted for 3 cycles at Q=4 (LO=0, HI=9) -> Q stays 4, ENP=0, ENT=1; counting resumes with 5 after HOLD drops. HOLD while Q==HI suppresses the wrap.
- START with LO=7, HI=5 -> ERR=1, stays IDLE, no load. A subsequent valid START clears ERR.
- STOP and HOLD both high in RUN -> ABORT wins (Q cleared to 0). STOP in LOAD -> Q=LO, then cleared to 0 next edge.

Source files
------------

// File: rtl/cnt163_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cnt163_seq_ctrl
//
// Sequencing controller for a single 74x163-style synchronous counter.
// Turns the free-running counter into a programmable-range modulo counter:
// it counts CFG_LO..CFG_HI for CYCLES passes (0 = continuous). It supports
// pause (HOLD), abort (STOP) and completion status (DONE, PASS_CNT).
//
// Ports
//   CLK        system clock, rising edge, shared with the counter
//   RST_L      asynchronous active-low reset
//   START      level sampled in IDLE; starts a run
//   STOP       abort request (LOAD and RUN only)
//   HOLD       pause request (RUN only)
//   CFG_LO     low bound of the count range, latched on an accepted START
//   CFG_HI     high bound of the count range, latched on an accepted START
//   CYCLES     number of passes, 0 = continuous, latched on an accepted START
//   CNT_Q      counter present state
//   CNT_CLR_L  counter sync clear, active low (held low while in reset)
//   CNT_LD_L   counter sync load, active low
//   CNT_ENP    counter ENP
//   CNT_ENT    counter ENT
//   CNT_D      counter parallel load data
//   BUSY       high in LOAD, RUN and ABORT
//   DONE       one-cycle pulse on normal completion
//   WRAP_P     high in each RUN cycle that ends a pass
//   ERR        sticky: a START was rejected because CFG_LO > CFG_HI
//   PASS_CNT   passes completed in the current run
// -----------------------------------------------------------------------------
module cnt163_seq_ctrl #(
    parameter int W  = 4,
    parameter int PW = 4
) (
    input  logic          CLK,
    input  logic          RST_L,
    input  logic          START,
    input  logic          STOP,
    input  logic          HOLD,
    input  logic [W-1:0]  CFG_LO,
    input  logic [W-1:0]  CFG_HI,
    input  logic [PW-1:0] CYCLES,
    input  logic [W-1:0]  CNT_Q,
    output logic          CNT_CLR_L,
    output logic          CNT_LD_L,
    output logic          CNT_ENP,
    output logic          CNT_ENT,
    output logic [W-1:0]  CNT_D,
    output logic          BUSY,
    output logic          DONE,
    output logic          WRAP_P,
    output logic          ERR,
    output logic [PW-1:0] PASS_CNT
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        DONE_S = 3'd3,
        ABORT  = 3'd4
    } state_t;

    state_t        state_reg,  state_next;
    logic [W-1:0]  lo_reg,     lo_next;
    logic [W-1:0]  hi_reg,     hi_next;
    logic [PW-1:0] cyc_reg,    cyc_next;
    logic [PW-1:0] pass_reg,   pass_next;
    logic          err_reg,    err_next;

    logic          clr_l_int;
    logic [PW-1:0] pass_inc;

    // Pass count after the pass ending this cycle; wraps mod 2^PW.
    assign pass_inc = pass_reg + {{(PW-1){1'b0}}, 1'b1};

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state_reg <= IDLE;
            lo_reg    <= '0;
            hi_reg    <= '0;
            cyc_reg   <= '0;
            pass_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            lo_reg    <= lo_next;
            hi_reg    <= hi_next;
            cyc_reg   <= cyc_next;
            pass_reg  <= pass_next;
            err_reg   <= err_next;
        end
    end

    // Counter controls are combinational so the counter acts on the same
    // edge as the state transition that they accompany.
    always_comb begin
        state_next = state_reg;
        lo_next    = lo_reg;
        hi_next    = hi_reg;
        cyc_next   = cyc_reg;
        pass_next  = pass_reg;
        err_next   = err_reg;
        clr_l_int  = 1'b1;
        CNT_LD_L   = 1'b1;
        CNT_ENP    = 1'b0;
        CNT_ENT    = 1'b0;
        CNT_D      = '0;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        WRAP_P     = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (START) begin
                    if (CFG_LO <= CFG_HI) begin
                        lo_next    = CFG_LO;
                        hi_next    = CFG_HI;
                        cyc_next   = CYCLES;
                        pass_next  = '0;
                        err_next   = 1'b0;
                        state_next = LOAD;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end

            LOAD: begin
                BUSY     = 1'b1;
                CNT_LD_L = 1'b0;
                CNT_D    = lo_reg;
                // The load still happens on an aborting edge.
                state_next = STOP ? ABORT : RUN;
            end

            RUN: begin
                BUSY = 1'b1;
                if (STOP) begin
                    state_next = ABORT;
                end else if (HOLD) begin
                    // ENT high with ENP low freezes Q.
                    CNT_ENT = 1'b1;
                end else if (CNT_Q != hi_reg) begin
                    CNT_ENP = 1'b1;
                    CNT_ENT = 1'b1;
                end else begin
                    WRAP_P    = 1'b1;
                    pass_next = pass_inc;
                    if ((cyc_reg != '0) && (pass_inc == cyc_reg)) begin
                        state_next = DONE_S;
                    end else begin
                        CNT_LD_L = 1'b0;
                        CNT_D    = lo_reg;
                    end
                end
            end

            DONE_S: begin
                DONE       = 1'b1;
                state_next = IDLE;
            end

            ABORT: begin
                BUSY       = 1'b1;
                clr_l_int  = 1'b0;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Clear is forced while reset is asserted so the counter is cleared on
    // every edge of the reset period.
    assign CNT_CLR_L = clr_l_int & RST_L;
    assign ERR       = err_reg;
    assign PASS_CNT  = pass_reg;

endmodule

// File: tb/tb_cnt163_seq_ctrl.sv
module tb_cnt163_seq_ctrl;

    logic       CLK = 1'b0;
    logic       RST_L = 1'b0;
    logic       START = 1'b0;
    logic       STOP = 1'b0;
    logic       HOLD = 1'b0;
    logic [3:0] CFG_LO = 4'd0;
    logic [3:0] CFG_HI = 4'd0;
    logic [3:0] CYCLES = 4'd0;
    logic [3:0] CNT_Q;
    logic       CNT_CLR_L, CNT_LD_L, CNT_ENP, CNT_ENT;
    logic [3:0] CNT_D;
    logic       BUSY, DONE, WRAP_P, ERR;
    logic [3:0] PASS_CNT;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    cnt163_seq_ctrl #(.W(4), .PW(4)) dut (
        .CLK(CLK), .RST_L(RST_L), .START(START), .STOP(STOP), .HOLD(HOLD),
        .CFG_LO(CFG_LO), .CFG_HI(CFG_HI), .CYCLES(CYCLES), .CNT_Q(CNT_Q),
        .CNT_CLR_L(CNT_CLR_L), .CNT_LD_L(CNT_LD_L), .CNT_ENP(CNT_ENP),
        .CNT_ENT(CNT_ENT), .CNT_D(CNT_D), .BUSY(BUSY), .DONE(DONE),
        .WRAP_P(WRAP_P), .ERR(ERR), .PASS_CNT(PASS_CNT)
    );

    // Behavioural 74x163: sync clear > sync load > count (ENP & ENT).
    logic [3:0] cnt_q = 4'd0;
    logic       preset_en = 1'b0;
    logic [3:0] preset_val = 4'd0;
    always @(posedge CLK) begin
        if (preset_en)       cnt_q <= preset_val;
        else if (!CNT_CLR_L) cnt_q <= 4'd0;
        else if (!CNT_LD_L)  cnt_q <= CNT_D;
        else if (CNT_ENP && CNT_ENT) cnt_q <= cnt_q + 4'd1;
    end
    assign CNT_Q = cnt_q;

    // Reference model of the run: phase, latched range and expected Q.
    localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_DONE = 3, P_ABORT = 4;
    int m_phase = P_IDLE;
    int m_lo = 0, m_hi = 0, m_cyc = 0, m_pass = 0, m_q = 0;
    int m_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_lo = 0; m_hi = 0; m_cyc = 0; m_pass = 0; m_err = 0;
    endtask

    task automatic check_outputs();
        logic run_act, at_hi, finish, e_wrap, e_ld;
        run_act = (m_phase == P_RUN) && !STOP;
        at_hi   = (m_q == m_hi);
        finish  = (m_cyc != 0) && (((m_pass + 1) % 16) == m_cyc);
        e_wrap  = run_act && !HOLD && at_hi;
        e_ld    = !((m_phase == P_LOAD) || (e_wrap && !finish));
        chk("q",     CNT_Q,    m_q[3:0]);
        chk("busy",  BUSY,     (m_phase == P_LOAD) || (m_phase == P_RUN) || (m_phase == P_ABORT));
        chk("done",  DONE,     m_phase == P_DONE);
        chk("wrap",  WRAP_P,   e_wrap);
        chk("pass",  PASS_CNT, m_pass[3:0]);
        chk("err",   ERR,      m_err != 0);
        chk("clr_l", CNT_CLR_L, m_phase != P_ABORT);
        chk("ld_l",  CNT_LD_L, e_ld);
        chk("ent",   CNT_ENT,  run_act && (HOLD || !at_hi));
        chk("enp",   CNT_ENP,  run_act && !HOLD && !at_hi);
        if (!e_ld) chk("d", CNT_D, m_lo[3:0]);
    endtask

    task automatic advance_model();
        case (m_phase)
            P_IDLE: if (START) begin
                if (CFG_LO <= CFG_HI) begin
                    m_lo = CFG_LO; m_hi = CFG_HI; m_cyc = CYCLES;
                    m_pass = 0; m_err = 0; m_phase = P_LOAD;
                end else begin
                    m_err = 1;
                end
            end
            P_LOAD: begin
                m_q = m_lo;
                m_phase = STOP ? P_ABORT : P_RUN;
            end
            P_RUN: begin
                if (STOP) m_phase = P_ABORT;
                else if (HOLD) m_phase = P_RUN;
                else if (m_q != m_hi) m_q = m_q + 1;
                else begin
                    m_pass = (m_pass + 1) % 16;
                    if (m_cyc != 0 && m_pass == m_cyc) m_phase = P_DONE;
                    else m_q = m_lo;
                end
            end
            P_DONE:  m_phase = P_IDLE;
            default: begin m_q = 0; m_phase = P_IDLE; end
        endcase
    endtask

    // One clock cycle: inputs driven at posedge+1, outputs checked at negedge.
    task automatic cycle(input logic s, input logic st, input logic h);
        START = s; STOP = st; HOLD = h;
        @(negedge CLK);
        check_outputs();
        advance_model();
        @(posedge CLK); #1;
    endtask

    task automatic cfg(input int lo, input int hi, input int cy);
        CFG_LO = lo[3:0]; CFG_HI = hi[3:0]; CYCLES = cy[3:0];
    endtask

    // Asynchronous reset for three edges, entered and left mid-cycle.
    task automatic async_reset();
        START = 0; STOP = 0; HOLD = 0;
        RST_L = 1'b0;
        #1;
        model_reset();
        chk("rst_clr_l", CNT_CLR_L, 1'b0);
        chk("rst_busy",  BUSY, 1'b0);
        chk("rst_done",  DONE, 1'b0);
        chk("rst_wrap",  WRAP_P, 1'b0);
        chk("rst_pass",  PASS_CNT, 4'd0);
        chk("rst_err",   ERR, 1'b0);
        chk("rst_ld_l",  CNT_LD_L, 1'b1);
        repeat (3) @(posedge CLK);
        #1;
        m_q = 0;
        chk("rst_q", CNT_Q, 4'd0);
        RST_L = 1'b1;
        #1;
        chk("rel_clr_l", CNT_CLR_L, 1'b1);
        chk("rel_busy",  BUSY, 1'b0);
    endtask

    initial begin
        // Power-up reset, then force the counter to 9 for the reset test.
        repeat (2) @(posedge CLK);
        #1 RST_L = 1'b1;
        preset_en = 1'b1; preset_val = 4'd9;
        @(posedge CLK); #1;
        preset_en = 1'b0;
        m_q = 9;
        chk("preset_q", CNT_Q, 4'd9);
        async_reset();
        $display("step: reset with counter at 9 checked");

        // LO=3 HI=6 CYCLES=2; config scrambled after the accept.
        cfg(3, 6, 2);
        cycle(1, 0, 0);
        cfg(12, 1, 7);
        repeat (11) cycle(0, 0, 0);
        chk("s1_pass", PASS_CNT, 4'd2);
        chk("s1_q",    CNT_Q, 4'd6);
        $display("step: range 3..6 x2 complete");

        // LO=HI=2 continuous, then abort.
        cfg(2, 2, 0);
        cycle(1, 0, 0);
        repeat (20) cycle(0, 0, 0);
        chk("s2_pass", PASS_CNT, 4'd3);
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        chk("s2_q", CNT_Q, 4'd0);
        repeat (2) cycle(0, 0, 0);
        $display("step: single-value continuous run and abort");

        // HOLD at Q=4 and at Q=HI.
        cfg(0, 9, 1);
        cycle(1, 0, 0);
        repeat (5) cycle(0, 0, 0);
        repeat (3) cycle(0, 0, 1);
        chk("s3_hold_q", CNT_Q, 4'd4);
        repeat (5) cycle(0, 0, 0);
        repeat (2) cycle(0, 0, 1);
        chk("s3_hold_hi_pass", PASS_CNT, 4'd0);
        repeat (3) cycle(0, 0, 0);
        chk("s3_pass", PASS_CNT, 4'd1);
        $display("step: hold mid-count and at high bound");

        // Rejected START, then a valid one clears ERR.
        cfg(7, 5, 1);
        cycle(1, 0, 0);
        chk("s4_err",  ERR, 1'b1);
        chk("s4_busy", BUSY, 1'b0);
        cycle(0, 0, 0);
        cfg(1, 3, 1);
        cycle(1, 0, 0);
        chk("s4_err_clr", ERR, 1'b0);
        repeat (5) cycle(0, 0, 0);
        $display("step: config error and recovery");

        // STOP+HOLD in RUN, then STOP in LOAD.
        cfg(5, 8, 0);
        cycle(1, 0, 0);
        repeat (3) cycle(0, 0, 0);
        cycle(0, 1, 1);
        cycle(0, 0, 0);
        chk("s5_q_abort", CNT_Q, 4'd0);
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        chk("s5_q_load", CNT_Q, 4'd5);
        cycle(0, 0, 0);
        chk("s5_q_clr", CNT_Q, 4'd0);
        cycle(0, 0, 0);
        $display("step: abort priority and abort during load");

        // Randomized run with occasional mid-run async reset.
        for (int i = 0; i < 800; i++) begin
            logic lo_gt;
            int lo, hi;
            lo = $urandom_range(0, 15);
            hi = $urandom_range(0, 15);
            lo_gt = ($urandom_range(0, 5) == 0);
            if (!lo_gt && lo > hi) begin int t; t = lo; lo = hi; hi = t; end
            cfg(lo, hi, $urandom_range(0, 3));
            if (i % 200 == 199) begin
                async_reset();
                $display("step: random async reset at iteration %0d", i);
            end else begin
                cycle(($urandom_range(0, 5) == 0), ($urandom_range(0, 29) == 0),
                      ($urandom_range(0, 4) == 0));
            end
        end
        $display("step: randomized sequence done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
